serial_add_sub: RTL and testbench

//   Multi-cycle, parametrised adder/subtractor for the ULA datapath.

---
 rtl/serial_add_sub.sv | 160 ++++++++++++++++
 tb/tb_serial_add_sub.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple chain.
// start/busy/done handshake with registered sum, carry, overflow and zero.
module serial_add_sub_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_s;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_c[0] = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_fa
            serial_add_sub_fa u_fa (
                .i_a(r_a[gi]),
                .i_b(r_b[gi]),
                .i_c(w_c[gi]),
                .o_s(w_s[gi]),
                .o_c(w_c[gi+1])
            );
        end
        // New digit enters at the top; after N steps the LSB digit is at bit 0.
        if (DIGIT == WIDTH) begin : g_res_full
            assign w_res_nxt = w_s;
        end else begin : g_res_shift
            assign w_res_nxt = {w_s, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= cin;
            r_res   <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_res   <= w_res_nxt;
            r_carry <= w_c[DIGIT];
            r_cnt   <= r_cnt + 1'b1;
            // On the last digit, w_c[DIGIT-1] is the carry into the MSB.
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_c[DIGIT];
                r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
                r_zero <= (w_res_nxt == '0);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign zero = r_zero;
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: W8/D1 directed,
// W8/D4 and W16/D16 random against a behavioural model.
module tb_serial_add_sub;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          t0;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    int          sel = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          busy_cnt = 0;
    exp_t        sbq[$];

    logic        st0, st1, st2;
    logic        bz0, bz1, bz2, dn0, dn1, dn2;
    logic        co0, co1, co2, ov0, ov1, ov2, ze0, ze1, ze2;
    logic [7:0]  sm0, sm1;
    logic [15:0] sm2;
    logic        w_busy, w_done, w_cout, w_ovf, w_zero;
    logic [15:0] w_sum;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);
    assign st2 = start && (sel == 2);

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(st0), .sub(sub),
        .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(bz0), .done(dn0), .sum(sm0),
        .cout(co0), .ovf(ov0), .zero(ze0)
    );
    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .start(st1), .sub(sub),
        .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(bz1), .done(dn1), .sum(sm1),
        .cout(co1), .ovf(ov1), .zero(ze1)
    );
    serial_add_sub #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
        .clk(clk), .rst_n(rst_n), .start(st2), .sub(sub),
        .a(a), .b(b), .cin(cin),
        .busy(bz2), .done(dn2), .sum(sm2),
        .cout(co2), .ovf(ov2), .zero(ze2)
    );

    always_comb begin
        w_busy = bz2;
        w_done = dn2;
        w_sum  = sm2;
        w_cout = co2;
        w_ovf  = ov2;
        w_zero = ze2;
        if (sel == 0) begin
            w_busy = bz0; w_done = dn0; w_sum = {8'h0, sm0};
            w_cout = co0; w_ovf = ov0; w_zero = ze0;
        end else if (sel == 1) begin
            w_busy = bz1; w_done = dn1; w_sum = {8'h0, sm1};
            w_cout = co1; w_ovf = ov1; w_zero = ze1;
        end
    end

    function automatic int n_of(int s);
        return (s == 0) ? 8 : (s == 1) ? 2 : 1;
    endfunction

    function automatic int w_of(int s);
        return (s == 2) ? 16 : 8;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(int w, logic [31:0] ra, logic [31:0] rb,
                                   logic rs, logic rc);
        exp_t e;
        logic [31:0] m, ml, bb, full, low;
        m    = (32'd1 << w) - 1;
        ml   = (32'd1 << (w - 1)) - 1;
        bb   = (rs ? ~rb : rb) & m;
        full = (ra & m) + bb + {31'd0, rc};
        low  = (ra & ml) + (bb & ml) + {31'd0, rc};
        e.sum  = full[15:0] & m[15:0];
        e.cout = full[w];
        e.ovf  = full[w] ^ low[w-1];
        e.zero = ((full & m) == 0);
        e.t0   = 0;
        e.lat  = 0;
        return e;
    endfunction

    function automatic exp_t mk(logic [15:0] s, logic c, logic o, logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z;
        e.t0 = 0; e.lat = 0;
        return e;
    endfunction

    // Call just after a posedge; returns just after the accepting edge.
    task automatic issue(logic [15:0] ia, logic [15:0] ib, logic is,
                         logic ic, exp_t e);
        a = ia; b = ib; sub = is; cin = ic; start = 1'b1;
        e.t0  = cyc;
        e.lat = n_of(sel) + 1;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (w_busy) busy_cnt++;
            if (w_done) begin
                exp_t e;
                n_done++;
                if (sbq.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("sum", {16'h0, w_sum}, {16'h0, e.sum});
                    check("cout", {31'h0, w_cout}, {31'h0, e.cout});
                    check("ovf", {31'h0, w_ovf}, {31'h0, e.ovf});
                    check("zero", {31'h0, w_zero}, {31'h0, e.zero});
                    check("latency", cyc - e.t0, e.lat);
                    check("busy_cycles", busy_cnt, n_of(sel));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int d0;
        logic [15:0] ra, rb;
        logic rs, rc;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, w_busy}, 0);
        check("rst_done", {31'h0, w_done}, 0);
        check("rst_sum", {16'h0, w_sum}, 0);
        check("rst_flags", {29'h0, w_cout, w_ovf, w_zero}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        sel = 0;
        issue(16'h7F, 16'h01, 0, 0, mk(16'h80, 0, 1, 0));
        repeat (8) @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
        issue(16'hFF, 16'h01, 0, 0, mk(16'h00, 1, 0, 1));
        repeat (10) @(posedge clk); #1;
        issue(16'h05, 16'h05, 1, 1, mk(16'h00, 1, 0, 1));
        repeat (10) @(posedge clk); #1;
        issue(16'h03, 16'h05, 1, 1, mk(16'hFE, 0, 0, 0));
        repeat (10) @(posedge clk); #1;

        // Ignored start mid-run, then back-to-back start in DONE.
        d0 = n_done;
        issue(16'h10, 16'h20, 0, 0, mk(16'h30, 0, 0, 0));
        repeat (2) @(posedge clk); #1;
        a = 16'h55; b = 16'h66; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk); #1;
        issue(16'h80, 16'h80, 0, 0, mk(16'h00, 1, 1, 1));
        repeat (3) @(posedge clk); #1;
        check("sum_hold_in_run", {16'h0, w_sum}, 32'h30);
        repeat (5) @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
        check("done_count_b2b", n_done - d0, 2);

        // Reset mid-run aborts with no done.
        issue(16'h12, 16'h34, 0, 0, mk(16'h46, 0, 0, 0));
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, w_busy}, 0);
        check("abort_done", {31'h0, w_done}, 0);
        check("abort_sum", {16'h0, w_sum}, 0);
        check("abort_flags", {29'h0, w_cout, w_ovf, w_zero}, 0);
        sbq.delete();
        d0 = n_done;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("abort_no_done", n_done - d0, 0);
        issue(16'h12, 16'h34, 0, 0, mk(16'h46, 0, 0, 0));
        repeat (10) @(posedge clk); #1;
        check("post_reset_done", n_done - d0, 1);

        for (int s = 1; s <= 2; s++) begin
            sel = s;
            @(posedge clk); #1;
            for (int i = 0; i < 1000; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rs = 1'($urandom);
                rc = 1'($urandom);
                if (s == 1) begin
                    ra[15:8] = '0;
                    rb[15:8] = '0;
                end
                issue(ra, rb, rs, rc, model(w_of(s), {16'h0, ra},
                                            {16'h0, rb}, rs, rc));
                repeat (n_of(s)) @(posedge clk); #1;
                if ($urandom_range(1, 0) == 1) begin
                    @(posedge clk); #1;
                end
            end
            repeat (4) @(posedge clk); #1;
        end

        check("pending", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
